// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start(0), address, separator(1), data, MSB first.
// Completed frames are presented as a held address/data word on a valid/ready handshake.
module serial_frame_rx #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  // state | meaning
  // IDLE  | line idle, waiting for a 0 start bit
  // ADDR  | shifting in ADDR_W address bits
  // SEP   | expecting the 1 separator bit
  // DATA  | shifting in DATA_W data bits, final bit completes the frame

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {IDLE, ADDR, SEP, DATA} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] data_next;
  logic              out_free;

  assign data_next = {data_sr[DATA_W-2:0], in};
  // The output word may be overwritten if empty or being consumed this very cycle.
  assign out_free  = !valid_o || ready_i;
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      addr_o      <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (!in) begin
            state <= ADDR;
            cnt   <= '0;
          end
        end
        ADDR: begin
          addr_sr <= {addr_sr[ADDR_W-2:0], in};
          if (cnt == CNT_W'(ADDR_W - 1)) begin
            state <= SEP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SEP: begin
          cnt <= '0;
          if (in) begin
            state <= DATA;
          end else begin
            frame_err_o <= 1'b1;
            state       <= IDLE;
          end
        end
        DATA: begin
          data_sr <= data_next;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            if (out_free) begin
              addr_o  <= addr_sr;
              data_o  <= data_next;
              valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx at default widths (8-bit address, 64-bit data).
module tb_serial_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser = 1'b1;
  logic        ready_i = 1'b1;
  logic [7:0]  addr_o;
  logic [63:0] data_o;
  logic        valid_o, busy_o, frame_err_o, overrun_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_edge = 0;
  int n_err = 0;
  int n_ov = 0;
  int n_valid = 0;
  int t1 = 0;
  int t2 = 0;
  logic valid_q = 1'b0;

  serial_frame_rx #(.ADDR_W(8), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .in(ser),
    .addr_o(addr_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and valid-rise counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err_o) n_err <= n_err + 1;
    if (overrun_o)   n_ov  <= n_ov + 1;
    if (valid_o && !valid_q) n_valid <= n_valid + 1;
    valid_q <= valid_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ser = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_hdr(input logic [7:0] a, input logic sep);
    ser = 1'b0;
    tick();
    start_edge = cyc;
    check("busy_after_start", 64'(busy_o), 64'd1);
    for (int i = 7; i >= 0; i--) begin
      ser = a[i];
      tick();
    end
    ser = sep;
    tick();
    ser = 1'b1;
  endtask

  task automatic send_data(input logic [63:0] d, input logic r_last);
    for (int i = 63; i >= 0; i--) begin
      if (i == 0) ready_i = r_last;
      ser = d[i];
      tick();
    end
    ser = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [63:0] d);
    send_hdr(a, 1'b1);
    send_data(d, ready_i);
  endtask

  initial begin
    // Reset
    rst = 1'b1; ser = 1'b1; ready_i = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_err", 64'(frame_err_o), 64'd0);
    check("rst_ovr", 64'(overrun_o), 64'd0);
    rst = 1'b0;
    idle(10);

    // Single frame; consumer samples valid on the 74th edge counting from the start-bit edge
    send_frame(8'h55, 64'h100);
    check("f1_valid", 64'(valid_o), 64'd1);
    check("f1_addr", 64'(addr_o), 64'h55);
    check("f1_data", data_o, 64'h100);
    check("f1_latency", 64'(cyc + 1 - start_edge), 64'd74);
    idle(1);
    check("f1_valid_drop", 64'(valid_o), 64'd0);
    check("f1_busy_idle", 64'(busy_o), 64'd0);
    idle(2);
    check("f1_nvalid", 64'(n_valid), 64'd1);
    check("f1_nerr", 64'(n_err), 64'd0);
    check("f1_novr", 64'(n_ov), 64'd0);

    // Back-to-back frames
    send_frame(8'hAA, 64'd128);
    t1 = cyc;
    check("b2b1_valid", 64'(valid_o), 64'd1);
    check("b2b1_addr", 64'(addr_o), 64'hAA);
    check("b2b1_data", data_o, 64'd128);
    send_frame(8'h01, 64'hFFFF_FFFF_FFFF_FFFF);
    t2 = cyc;
    check("b2b2_valid", 64'(valid_o), 64'd1);
    check("b2b2_addr", 64'(addr_o), 64'h01);
    check("b2b2_data", data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b_spacing", 64'(t2 - t1), 64'd74);
    idle(2);
    check("b2b_nvalid", 64'(n_valid), 64'd3);

    // Bad separator
    send_hdr(8'h3C, 1'b0);
    check("sep_err", 64'(frame_err_o), 64'd1);
    check("sep_busy", 64'(busy_o), 64'd0);
    check("sep_valid", 64'(valid_o), 64'd0);
    idle(1);
    check("sep_err_pulse", 64'(frame_err_o), 64'd0);
    send_frame(8'h3C, 64'd7);
    check("sep_next_valid", 64'(valid_o), 64'd1);
    check("sep_next_addr", 64'(addr_o), 64'h3C);
    check("sep_next_data", data_o, 64'd7);
    idle(2);
    check("sep_nerr", 64'(n_err), 64'd1);
    check("sep_nvalid", 64'(n_valid), 64'd4);

    // Overrun with ready low
    ready_i = 1'b0;
    send_frame(8'h11, 64'h1);
    check("ovr_h_valid", 64'(valid_o), 64'd1);
    check("ovr_h_addr", 64'(addr_o), 64'h11);
    idle(3);
    check("ovr_hold_valid", 64'(valid_o), 64'd1);
    send_frame(8'h22, 64'h2);
    check("ovr_pulse", 64'(overrun_o), 64'd1);
    check("ovr_keep_valid", 64'(valid_o), 64'd1);
    check("ovr_keep_addr", 64'(addr_o), 64'h11);
    check("ovr_keep_data", data_o, 64'h1);
    idle(1);
    check("ovr_pulse_end", 64'(overrun_o), 64'd0);
    ready_i = 1'b1;
    idle(1);
    check("ovr_acc_valid", 64'(valid_o), 64'd0);
    check("ovr_acc_addr", 64'(addr_o), 64'h11);
    check("ovr_acc_data", data_o, 64'h1);
    idle(1);
    check("ovr_novr", 64'(n_ov), 64'd1);
    check("ovr_nvalid", 64'(n_valid), 64'd5);

    // Reset during the data field, on data bit 30
    send_hdr(8'h5A, 1'b1);
    for (int i = 63; i >= 34; i--) begin
      ser = i[0];
      tick();
    end
    rst = 1'b1;
    ser = 1'b0;
    tick();
    rst = 1'b0;
    ser = 1'b1;
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_valid", 64'(valid_o), 64'd0);
    check("mrst_addr", 64'(addr_o), 64'd0);
    check("mrst_data", data_o, 64'd0);
    idle(40);
    check("mrst_idle_busy", 64'(busy_o), 64'd0);
    check("mrst_nvalid", 64'(n_valid), 64'd5);
    send_frame(8'h80, 64'hDEAD_BEEF);
    check("mrst_next_valid", 64'(valid_o), 64'd1);
    check("mrst_next_addr", 64'(addr_o), 64'h80);
    check("mrst_next_data", data_o, 64'hDEAD_BEEF);
    idle(2);

    // Second frame completes on the same cycle ready rises
    ready_i = 1'b0;
    send_frame(8'h33, 64'h3);
    check("same_h_addr", 64'(addr_o), 64'h33);
    idle(2);
    send_hdr(8'h44, 1'b1);
    send_data(64'h4, 1'b1);
    check("same_ovr", 64'(overrun_o), 64'd0);
    check("same_valid", 64'(valid_o), 64'd1);
    check("same_addr", 64'(addr_o), 64'h44);
    check("same_data", data_o, 64'h4);
    idle(1);
    check("same_acc_valid", 64'(valid_o), 64'd0);
    check("same_acc_addr", 64'(addr_o), 64'h44);
    idle(2);
    check("end_novr", 64'(n_ov), 64'd1);
    check("end_nerr", 64'(n_err), 64'd1);
    check("end_nvalid", 64'(n_valid), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
